sobel_gradient_pipe: RTL and testbench
======================================

SOBEL_GRADIENT_PIPE -- requirements
Module: sobel_gradient_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning window pixel width in bits (unsigned).
REQ-002 SHALL have parameter GRAD_W, default PIX_W+3, meaning output gradient width; elaboration SHALL fail if GRAD_W < PIX_W+3.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: n_rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: in_valid  in  1  window present; in_ready  out  1  window accepted when in_valid && in_ready.
REQ-006 SHALL have ports: window  in  9 x PIX_W  3x3 window, P0..P8 row-major, P0 top-left.
REQ-007 SHALL have ports: mode  in  2  00 |gx|, 01 |gy|, 10 |gx|+|gy|, 11 max(|gx|,|gy|).
REQ-008 SHALL have ports: threshold  in  GRAD_W  edge threshold, sampled with window.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; grad  out  GRAD_W  unsigned result; sign_x  out  1  gx<0; sign_y  out  1  gy<0; edge  out  1  grad >= threshold.

Function
REQ-010 SHALL compute gx = (P2-P0) + 2(P5-P3) + (P8-P6) and gy = (P6-P0) + 2(P7-P1) + (P8-P2) in signed PIX_W+3 arithmetic, no overflow.
REQ-011 SHALL take absolute values in PIX_W+2 unsigned bits; mode 10 sum in PIX_W+3 bits, zero-extended to GRAD_W.
REQ-012 SHALL be a 3-stage pipeline: S1 capture window/mode/threshold, S2 signed gx/gy, S3 abs, mode select, compare.
REQ-013 SHALL give latency of exactly 3 cycles from accepting handshake to out_valid with out_ready held high.
REQ-014 SHALL sustain throughput of one window per cycle while out_ready=1.
REQ-015 SHALL advance all stages together when adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-016 SHALL, when adv=0, hold every stage register and grad/sign/edge stable while out_valid=1.
REQ-017 SHALL use a per-stage valid bit; bubbles (in_valid=0 on adv) SHALL propagate as invalid stages and be collapsed only by adv.
REQ-018 SHALL bind mode and threshold to the window sampled with it; changes mid-pipeline SHALL NOT affect in-flight results.
REQ-019 SHALL, for mode 11 with |gx|==|gy|, output that common value; sign_x/sign_y SHALL be 0 when the respective gradient is 0.
REQ-020 SHALL keep out_valid=0 and drive grad/sign/edge to 0 when S3 is invalid.

Reset
REQ-021 SHALL, on n_rst low, clear all stage valid bits immediately, and clear out_valid, grad, sign_x, sign_y and edge to 0.
REQ-022 SHALL discard in-flight windows on reset mid-operation; first output after n_rst release appears 3 cycles after the next accepted window.
REQ-023 SHALL drive in_ready=1 during and after reset, since out_valid=0.

Configuration
REQ-024 SHALL honour macro SOBEL_EDGE_THRESH_EN: defined -> edge computed per REQ-009 and threshold used; undefined -> edge tied 0, threshold ignored, compare logic absent.

Structure
REQ-025 SHALL place mode enum (MODE_GX, MODE_GY, MODE_SUM, MODE_MAX) and the 3x3 window typedef in package sobel_pkg.
REQ-026 SHALL instantiate sub-module sobel_kernel, combinational, computing signed gx/gy from one window; used in S2.

Verification
REQ-027 SHALL cover: P0,P3,P6=0, P2,P5,P8=255, mode 00 -> grad=1020, sign_x=0, valid 3 cycles after accept.
REQ-028 SHALL cover: top row 255, bottom row 0, mode 10 -> gy=-1020, grad=1020, sign_y=1, sign_x=0.
REQ-029 SHALL cover: uniform window 100, threshold 1, mode 11 -> grad=0, edge=0 (macro on) and edge=0 (macro off).
REQ-030 SHALL cover: 8 back-to-back windows with out_ready low for cycles 4-6 -> no loss or duplication, outputs in order, in_ready low exactly while stalled with out_valid=1.
REQ-031 SHALL cover: n_rst asserted with 3 windows in flight -> out_valid=0 at once; nothing from those windows emerges after release.
REQ-032 SHALL cover: mode switched 00->01 on consecutive windows -> each result uses its own mode.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel gradient pipeline: window geometry, result-mode encoding
// and the 3x3 window type at the default pixel width.
// Ports: none (package only).
package sobel_pkg;

  // Number of taps in a 3x3 window.
  localparam int WIN_N     = 9;
  localparam int PIX_W_DEF = 8;

  // Selects what is reported on grad.
  typedef enum logic [1:0] {
    MODE_GX  = 2'b00,  // |gx|
    MODE_GY  = 2'b01,  // |gy|
    MODE_SUM = 2'b10,  // |gx| + |gy|
    MODE_MAX = 2'b11   // max(|gx|, |gy|)
  } mode_t;

  // 3x3 window, P0..P8 row-major, P0 (top-left) in the least significant lane.
  typedef logic [WIN_N-1:0][PIX_W_DEF-1:0] window_t;

  // Smallest result width that holds |gx|+|gy| without overflow.
  function automatic int min_grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_gradient_pipe_if.sv
// Handshake bundle for sobel_gradient_pipe: window-in channel and gradient-out channel.
// master: window producer / result consumer (drives in_valid, window, mode, threshold, out_ready).
// slave:  the pipeline (drives in_ready, out_valid, grad, sign_x, sign_y, is_edge).
interface sobel_gradient_pipe_if #(
  parameter int PIX_W  = 8,
  parameter int GRAD_W = PIX_W + 3
);
  import sobel_pkg::*;

  // Input channel; mode and threshold travel with the window they are sampled with.
  logic                         in_valid;
  logic                         in_ready;
  logic [WIN_N-1:0][PIX_W-1:0]  window;
  logic [1:0]                   mode;
  logic [GRAD_W-1:0]            threshold;

  // Output channel. is_edge carries the grad >= threshold flag ('edge' is a reserved word).
  logic                         out_valid;
  logic                         out_ready;
  logic [GRAD_W-1:0]            grad;
  logic                         sign_x;
  logic                         sign_y;
  logic                         is_edge;

  modport master (
    output in_valid, window, mode, threshold, out_ready,
    input  in_ready, out_valid, grad, sign_x, sign_y, is_edge
  );

  modport slave (
    input  in_valid, window, mode, threshold, out_ready,
    output in_ready, out_valid, grad, sign_x, sign_y, is_edge
  );

endinterface

// File: rtl/sobel_kernel.sv
// Combinational Sobel kernel: signed horizontal and vertical gradients of one 3x3 window.
// Ports: window (9 x PIX_W, P0 top-left, row-major) in; gx, gy (signed PIX_W+3) out.
// Latency 0; no handshake, the caller registers the results.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [WIN_N-1:0][PIX_W-1:0] window,
  output logic signed [PIX_W+2:0]     gx,
  output logic signed [PIX_W+2:0]     gy
);

  localparam int SW = PIX_W + 3;

  // Zero-extend each tap into the signed domain; +-4*(2^PIX_W-1) fits in SW bits.
  logic signed [SW-1:0] p [WIN_N];

  for (genvar i = 0; i < WIN_N; i++) begin : g_ext
    assign p[i] = $signed({3'b000, window[i]});
  end

  // Right column minus left column, middle row weighted by 2.
  assign gx = (p[2] - p[0]) + ((p[5] - p[3]) <<< 1) + (p[8] - p[6]);
  // Bottom row minus top row, middle column weighted by 2.
  assign gy = (p[6] - p[0]) + ((p[7] - p[1]) <<< 1) + (p[8] - p[2]);

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel gradient pipeline: S1 captures window/mode/threshold, S2 holds signed
// gx/gy from sobel_kernel, S3 holds the registered magnitude, signs and edge flag.
// Latency 3 cycles from accept to out_valid; one window per cycle while out_ready is high.
// Backpressure: all stages advance together on adv = !out_valid || out_ready; in_ready = adv.
// Ports: clk, n_rst (async active-low), bus (sobel_gradient_pipe_if.slave).
// Build option SOBEL_EDGE_THRESH_EN: when defined, is_edge = grad >= threshold; otherwise
// is_edge is tied low and the threshold is not stored or compared.
module sobel_gradient_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int GRAD_W = PIX_W + 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sobel_gradient_pipe_if.slave bus
);

  localparam int SW = PIX_W + 3;  // signed gradient width
  localparam int AW = PIX_W + 2;  // magnitude width
  localparam logic [AW-1:0] ONE_A = AW'(1);

  if (GRAD_W < min_grad_w(PIX_W)) begin : g_bad_grad_w
    $error("sobel_gradient_pipe: GRAD_W must be at least PIX_W+3");
  end

  // Pipeline control
  logic adv;
  logic s1_vld, s2_vld, s3_vld;

  // Stage data
  logic [WIN_N-1:0][PIX_W-1:0] s1_win;
  mode_t                       s1_mode, s2_mode;
  logic signed [SW-1:0]        k_gx, k_gy;
  logic signed [SW-1:0]        s2_gx, s2_gy;

  // S3 combinational results and registered outputs
  logic [AW-1:0]     abs_x, abs_y;
  logic [SW-1:0]     sel;
  logic [GRAD_W-1:0] grad_nxt;
  logic              edge_nxt;
  logic [GRAD_W-1:0] s3_grad;
  logic              s3_sx, s3_sy, s3_edge;

  // A stage may move only if whatever sits in S3 is leaving or S3 is empty.
  assign adv          = !s3_vld || bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (adv) begin
      s1_vld <= bus.in_valid;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  // Data registers need no reset: they are only observed through the valid bits.
  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      s1_win  <= bus.window;
      s1_mode <= mode_t'(bus.mode);
    end
    if (adv && s1_vld) begin
      s2_gx   <= k_gx;
      s2_gy   <= k_gy;
      s2_mode <= s1_mode;
    end
  end

  sobel_kernel #(
    .PIX_W (PIX_W)
  ) u_kernel (
    .window (s1_win),
    .gx     (k_gx),
    .gy     (k_gy)
  );

  // |g| <= 4*(2^PIX_W-1) < 2^(PIX_W+2), so the low AW bits negated give the magnitude.
  assign abs_x = s2_gx[SW-1] ? (~s2_gx[AW-1:0] + ONE_A) : s2_gx[AW-1:0];
  assign abs_y = s2_gy[SW-1] ? (~s2_gy[AW-1:0] + ONE_A) : s2_gy[AW-1:0];

  always_comb begin
    sel = '0;
    case (s2_mode)
      MODE_GX:  sel = {1'b0, abs_x};
      MODE_GY:  sel = {1'b0, abs_y};
      MODE_SUM: sel = {1'b0, abs_x} + {1'b0, abs_y};
      MODE_MAX: sel = (abs_x >= abs_y) ? {1'b0, abs_x} : {1'b0, abs_y};
      default:  sel = '0;
    endcase
  end

  assign grad_nxt = GRAD_W'(sel);

`ifdef SOBEL_EDGE_THRESH_EN
  // Threshold rides alongside its window so later threshold changes never reach it.
  logic [GRAD_W-1:0] s1_thr, s2_thr;

  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) s1_thr <= bus.threshold;
    if (adv && s1_vld)       s2_thr <= s1_thr;
  end

  assign edge_nxt = (grad_nxt >= s2_thr);
`else
  logic unused_thr;
  assign unused_thr = ^bus.threshold;
  assign edge_nxt   = 1'b0;
`endif

  // Outputs are zero whenever S3 holds a bubble, so a consumer never sees stale data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s3_grad <= '0;
      s3_sx   <= 1'b0;
      s3_sy   <= 1'b0;
      s3_edge <= 1'b0;
    end else if (adv) begin
      if (s2_vld) begin
        s3_grad <= grad_nxt;
        s3_sx   <= s2_gx[SW-1];
        s3_sy   <= s2_gy[SW-1];
        s3_edge <= edge_nxt;
      end else begin
        s3_grad <= '0;
        s3_sx   <= 1'b0;
        s3_sy   <= 1'b0;
        s3_edge <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s3_vld;
  assign bus.grad      = s3_grad;
  assign bus.sign_x    = s3_sx;
  assign bus.sign_y    = s3_sy;
  assign bus.is_edge   = s3_edge;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Self-checking bench for sobel_gradient_pipe: directed corner windows, a stalled burst,
// a mid-flight reset and a randomized run, all scored against an integer reference model.
module tb_sobel_gradient_pipe;
  import sobel_pkg::*;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = PIX_W + 3;

  typedef struct packed {
    logic [GRAD_W-1:0] grad;
    logic              sx;
    logic              sy;
    logic              ed;
  } exp_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  sobel_gradient_pipe_if #(.PIX_W(PIX_W), .GRAD_W(GRAD_W)) bus ();

  sobel_gradient_pipe #(
    .PIX_W  (PIX_W),
    .GRAD_W (GRAD_W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: Sobel equations evaluated on plain integers.
  function automatic exp_t model(input window_t w, input logic [1:0] m, input logic [GRAD_W-1:0] thr);
    int p[9];
    int gx, gy, ax, ay, g;
    exp_t e;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i]);
    gx = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
    gy = (p[6] - p[0]) + 2 * (p[7] - p[1]) + (p[8] - p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (int'(m))
      0:       g = ax;
      1:       g = ay;
      2:       g = ax + ay;
      default: g = (ax > ay) ? ax : ay;
    endcase
    e.grad = GRAD_W'(g);
    e.sx   = (gx < 0);
    e.sy   = (gy < 0);
`ifdef SOBEL_EDGE_THRESH_EN
    e.ed   = (g >= int'(thr));
`else
    e.ed   = 1'b0;
`endif
    return e;
  endfunction

  function automatic window_t rand_win();
    window_t w;
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 3))
        0:       w[i] = '0;
        1:       w[i] = '1;
        default: w[i] = PIX_W'($urandom_range(0, 255));
      endcase
    end
    return w;
  endfunction

  // Scoreboard: windows enter the queue on accept, leave on output handshake.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("out_has_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("grad",   32'(bus.grad),    32'(mon_e.grad));
          chk("sign_x", 32'(bus.sign_x),  32'(mon_e.sx));
          chk("sign_y", 32'(bus.sign_y),  32'(mon_e.sy));
          chk("edge",   32'(bus.is_edge), 32'(mon_e.ed));
        end
      end
      if (!bus.out_valid)
        chk("idle_outputs_zero", 32'({bus.grad, bus.sign_x, bus.sign_y, bus.is_edge}), 0);
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.window, bus.mode, bus.threshold));
    end
  end

  // Single window into an empty pipe; reports cycles from accept to out_valid and the result.
  task automatic send_directed(input window_t w, input logic [1:0] m, input logic [GRAD_W-1:0] thr,
                               output int lat, output logic [GRAD_W-1:0] g,
                               output logic sx, output logic sy, output logic ed);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.window    = w;
    bus.mode      = m;
    bus.threshold = thr;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    chk("dir_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 99; g = '0; sx = 1'b0; sy = 1'b0; ed = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.out_valid && lat == 99) begin
        lat = c; g = bus.grad; sx = bus.sign_x; sy = bus.sign_y; ed = bus.is_edge;
      end
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && (exp_q.size() != 0 || bus.out_valid); c++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    window_t           w;
    int                lat, sent, acc, cnt;
    logic [GRAD_W-1:0] g;
    logic              sx, sy, ed;
    logic [GRAD_W-1:0] got [4];

    bus.in_valid  = 1'b0;
    bus.window    = '0;
    bus.mode      = 2'b00;
    bus.threshold = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 1);
    chk("rst_outputs",   32'({bus.grad, bus.sign_x, bus.sign_y, bus.is_edge}), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Vertical edge: left column 0, right column 255, mode |gx|
    for (int i = 0; i < 9; i++) w[i] = (i % 3 == 0) ? 8'd0 : ((i % 3 == 2) ? 8'd255 : 8'd128);
    send_directed(w, 2'b00, GRAD_W'(500), lat, g, sx, sy, ed);
    chk("vedge_latency", 32'(lat), 3);
    chk("vedge_grad",    32'(g), 1020);
    chk("vedge_sign_x",  32'(sx), 0);

    // Horizontal edge: top row 255, bottom row 0, mode |gx|+|gy|
    for (int i = 0; i < 9; i++) w[i] = (i / 3 == 0) ? 8'd255 : ((i / 3 == 2) ? 8'd0 : 8'd77);
    send_directed(w, 2'b10, GRAD_W'(2000), lat, g, sx, sy, ed);
    chk("hedge_latency", 32'(lat), 3);
    chk("hedge_grad",    32'(g), 1020);
    chk("hedge_sign_y",  32'(sy), 1);
    chk("hedge_sign_x",  32'(sx), 0);

    // Uniform window, threshold 1, mode max
    for (int i = 0; i < 9; i++) w[i] = 8'd100;
    send_directed(w, 2'b11, GRAD_W'(1), lat, g, sx, sy, ed);
    chk("flat_grad", 32'(g), 0);
    chk("flat_edge", 32'(ed), 0);

    // Mode switched between consecutive windows; mode changes after acceptance must not leak
    for (int i = 0; i < 9; i++) w[i] = (i % 3 == 0) ? 8'd0 : ((i % 3 == 2) ? 8'd255 : 8'd128);
    @(posedge clk); #1;
    bus.window = w; bus.mode = 2'b00; bus.in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mode = 2'b01;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.mode = 2'b10; bus.threshold = '1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && cnt < 4) begin
        got[cnt] = bus.grad;
        cnt++;
      end
    end
    chk("modesw_count", 32'(cnt), 2);
    chk("modesw_first_gx",  32'(got[0]), 1020);
    chk("modesw_second_gy", 32'(got[1]), 0);

    // Eight back-to-back windows, consumer stalls during burst cycles 4..6
    sent = 0;
    @(posedge clk); #1;
    bus.window = rand_win(); bus.mode = 2'($urandom_range(0, 3));
    bus.threshold = GRAD_W'($urandom_range(0, 2047)); bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (cyc >= 4 && cyc <= 6) begin
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        chk("stall_in_ready",  32'(bus.in_ready), 0);
      end else begin
        chk("run_in_ready", 32'(bus.in_ready), 1);
      end
      acc = int'(bus.in_ready);
      @(posedge clk); #1;
      if (acc != 0) begin
        sent++;
        if (sent < 8) begin
          bus.window = rand_win(); bus.mode = 2'($urandom_range(0, 3));
          bus.threshold = GRAD_W'($urandom_range(0, 2047));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("burst_sent", 32'(sent), 8);
    bus.in_valid = 1'b0;
    drain();

    // Reset with three windows in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.window = rand_win(); bus.in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(negedge clk);
      cnt = int'(bus.in_ready);
      @(posedge clk); #1;
      if (cnt != 0) begin
        acc++;
        if (acc < 3) bus.window = rand_win(); else bus.in_valid = 1'b0;
      end
    end
    chk("inflight_accepts",  32'(acc), 3);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready",  32'(bus.in_ready), 1);
    chk("mid_rst_outputs",   32'({bus.grad, bus.sign_x, bus.sign_y, bus.is_edge}), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("post_rst_silent", 32'(cnt), 0);
    for (int i = 0; i < 9; i++) w[i] = PIX_W'(i * 20);
    send_directed(w, 2'b10, GRAD_W'(0), lat, g, sx, sy, ed);
    chk("post_rst_latency", 32'(lat), 3);

    // Randomized traffic with random gaps and random backpressure
    sent = 0;
    acc  = 0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5000 && sent < 300; c++) begin
      @(posedge clk); #1;
      if (acc != 0) bus.in_valid = 1'b0;
      acc = 0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid && $urandom_range(0, 4) != 0) begin
        bus.window    = rand_win();
        bus.mode      = 2'($urandom_range(0, 3));
        bus.threshold = GRAD_W'($urandom_range(0, 2047));
        bus.in_valid  = 1'b1;
      end else if (!bus.in_valid) begin
        bus.mode      = 2'($urandom_range(0, 3));
        bus.threshold = GRAD_W'($urandom_range(0, 2047));
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        acc = 1;
        sent++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("random_sent", 32'(sent), 300);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
